decoder_scan_ctrl: RTL and testbench
====================================

Name: decoder_scan_ctrl

Overview:
Parametrised, registered N-to-2^N one-hot decoder; generalises the team's combinational 3-to-8 decoder. Adds an enable, a registered output and an autonomous scan mode that walks the active output through all 2^N positions with a programmable dwell time. Used as a row/digit select driver for multiplexed displays and as a chip-select generator for banked peripherals.

Parameters:
N, 3, select width; output width is 2^N.
DWELL, 4, clock cycles each output stays active in scan mode; legal range 1..65535.
CW, 16, dwell counter width; requires DWELL <= 2^CW-1.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  global enable; 0 forces outputs inactive
mode  input  1  0 = direct decode, 1 = scan
load  input  1  direct mode: capture sel this cycle
sel  input  N  direct-mode select index
y  output  2^N  registered one-hot (or all-zero) select
idx  output  N  index currently driven on y
busy  output  1  1 while in SCAN state
wrap  output  1  one-cycle pulse when scan returns from 2^N-1 to 0

Behaviour:
- Reset (rst=1 at clock edge): y=0, idx=0, busy=0, wrap=0, dwell counter=0, state=IDLE. rst has priority over all other inputs.
- States: IDLE, DIRECT, SCAN. State and outputs update only on clk rising edge.
- IDLE: y=0. en=1 & mode=0 -> DIRECT. en=1 & mode=1 -> SCAN.
- DIRECT: when load=1, y = 1<<sel and idx=sel on the next edge (latency 1). load=0 holds y/idx. Entry from IDLE with load=1 in the same cycle captures sel immediately. Entry without load gives y=0 until the first load.
- SCAN: on entry y=1<<0, idx=0, counter=0, busy=1. The counter increments every cycle. When counter==DWELL-1: counter=0 and idx advances by 1. From 2^N-1 idx wraps to 0, and wrap=1 for exactly the cycle in which idx==0 is first presented. With DWELL=1, idx advances every cycle. sel and load are ignored in SCAN.
- Mode change while en=1: DIRECT->SCAN restarts the scan at idx 0. SCAN->DIRECT keeps y/idx until the next load. busy drops on the next edge.
- en=0 in any state: next edge y=0, busy=0, wrap=0, state=IDLE. Scan position is discarded, and re-enabling scan restarts at idx 0.
- Invariant: y has at most one bit set; y!=0 implies y==1<<idx.
- wrap is never asserted outside SCAN.

Optional Feature:
Macro DECODER_ACTIVE_LOW_EN.
- Defined: y is driven inverted (active-low select). The reset/inactive value is all-ones, and exactly one bit is 0 when active. idx, busy and wrap are unchanged.
- Undefined: active-high y as described above.

Decomposition:
- Package decoder_pkg holds the state enum (IDLE=2'd0, DIRECT=2'd1, SCAN=2'd2) and the mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
- One sub-module, dwell_timer (parameters DWELL, CW): inputs clk, rst, clr, run; output tick, asserted when count==DWELL-1.
- The top level contains the FSM, the index register and the one-hot decode.

Test Plan:
- Reset: assert rst for 2 cycles with en=1, mode=1 -> y=0, idx=0, busy=0, wrap=0 throughout; after release, SCAN entry gives y=8'h01 on the next edge.
- Direct decode, N=3: en=1, mode=0, load sel=0..7 on consecutive cycles -> y=8'h01,02,04,...,80, each one cycle after its load; load=0 holds 8'h80.
- Scan, N=3, DWELL=4: y steps 01->02->...->80->01, each value held 4 cycles; wrap is pulsed once every 32 cycles, coincident with y=8'h01; busy=1.
- DWELL=1 corner: y changes every cycle, wrap period is 8 cycles.
- Mid-operation events: drop en while y=8'h10 in scan -> y=0 next edge; re-enable -> restarts at 8'h01. Switch SCAN->DIRECT at y=8'h04 -> holds 8'h04 until load sel=6 gives 8'h40. Assert rst mid-scan -> y=0 next edge.
- DECODER_ACTIVE_LOW_EN defined: direct load sel=2 -> y=8'hFB; reset and en=0 -> y=8'hFF.

Source files
------------

// File: rtl/decoder_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared types and constants for the registered one-hot decoder with scan
// mode (decoder_scan_ctrl).
//   state_t     : controller states IDLE / DIRECT / SCAN
//   MODE_DIRECT : value of the 'mode' input selecting direct decode
//   MODE_SCAN   : value of the 'mode' input selecting autonomous scan
// ---------------------------------------------------------------------------
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_ctrl_dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
// Counts clock cycles while 'run' is high and flags the last cycle of each
// dwell period. The count wraps to zero on the cycle after tick, so tick
// recurs every DWELL cycles of continuous running.
// Parameters:
//   DWELL : dwell period in cycles (1..65535)
//   CW    : counter width, DWELL must fit in CW bits
// Ports:
//   clk  in  : system clock
//   rst  in  : synchronous active-high reset, clears the count
//   clr  in  : synchronous clear, clears the count (overrides run)
//   run  in  : count enable
//   tick out : high while count == DWELL-1
// ---------------------------------------------------------------------------
module dwell_timer #(
  parameter int DWELL = 4,
  parameter int CW    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count;

  // With DWELL=1 LAST is zero, so tick stays high and the count never moves.
  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (run) begin
      if (tick) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// ---------------------------------------------------------------------------
// decoder_scan_ctrl
// Registered N-to-2^N one-hot decoder with enable and an autonomous scan
// mode that walks the active output through every position, holding each
// for DWELL cycles. Used as a display row/digit driver or bank chip-select.
//
// Configuration macro: DECODER_ACTIVE_LOW_EN
//   defined   : y is active-low (idle value all-ones, one bit low when active)
//   undefined : y is active-high (idle value all-zeros)
//
// Parameters:
//   N     : select width, output width is 2^N
//   DWELL : cycles each output stays active while scanning (1..65535)
//   CW    : dwell counter width
// Ports:
//   clk  in        : system clock
//   rst  in        : synchronous active-high reset
//   en   in        : global enable, 0 returns to IDLE with outputs inactive
//   mode in        : 0 direct decode, 1 scan
//   load in        : direct mode, capture sel this cycle
//   sel  in  [N]   : direct-mode select index
//   y    out [2^N] : registered one-hot (or inactive) select
//   idx  out [N]   : index currently driven on y
//   busy out       : high while in SCAN
//   wrap out       : one-cycle pulse when scan returns from 2^N-1 to 0
// ---------------------------------------------------------------------------
module decoder_scan_ctrl
  import decoder_pkg::*;
#(
  parameter int N     = 3,
  parameter int DWELL = 4,
  parameter int CW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                load,
  input  logic [N-1:0]        sel,
  output logic [(1<<N)-1:0]   y,
  output logic [N-1:0]        idx,
  output logic                busy,
  output logic                wrap
);

  localparam int            W        = 1 << N;
  localparam logic [N-1:0]  IDX_LAST = '1;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [W-1:0]  Y_IDLE   = '1;
`else
  localparam logic [W-1:0]  Y_IDLE   = '0;
`endif

  state_t         state;
  state_t         next_state;
  logic           active;
  logic           next_active;
  logic [N-1:0]   next_idx;
  logic           next_wrap;
  logic [W-1:0]   next_y_hi;
  logic [W-1:0]   next_y;
  logic           tick;
  logic           timer_clr;
  logic           timer_run;

  // The timer only runs while we stay in SCAN; any other cycle (including
  // the one that enters SCAN) clears it so each scan starts a full dwell.
  assign timer_run = (state == SCAN);
  assign timer_clr = (state != SCAN) || (next_state != SCAN);

  dwell_timer #(
    .DWELL (DWELL),
    .CW    (CW)
  ) u_dwell_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .run  (timer_run),
    .tick (tick)
  );

  // 'active' tracks whether y should show a selected line at all; it is
  // kept separately from idx so DIRECT entry without a load can show an
  // inactive y while idx still holds a defined value.
  always_comb begin
    next_state  = state;
    next_idx    = idx;
    next_active = active;
    next_wrap   = 1'b0;

    if (!en) begin
      next_state  = IDLE;
      next_idx    = '0;
      next_active = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mode == MODE_SCAN) begin
            next_state  = SCAN;
            next_idx    = '0;
            next_active = 1'b1;
          end else begin
            next_state = DIRECT;
            if (load) begin
              next_idx    = sel;
              next_active = 1'b1;
            end
          end
        end

        DIRECT: begin
          if (mode == MODE_SCAN) begin
            next_state  = SCAN;
            next_idx    = '0;
            next_active = 1'b1;
          end else if (load) begin
            next_idx    = sel;
            next_active = 1'b1;
          end
        end

        SCAN: begin
          // Leaving for DIRECT freezes the current position until a load.
          if (mode == MODE_DIRECT) begin
            next_state = DIRECT;
          end else if (tick) begin
            next_idx  = idx + N'(1);
            next_wrap = (idx == IDX_LAST);
          end
        end

        default: begin
          next_state  = IDLE;
          next_idx    = '0;
          next_active = 1'b0;
        end
      endcase
    end
  end

  // One-hot decode of the next index, then the output polarity.
  always_comb begin
    next_y_hi = '0;
    if (next_active) begin
      next_y_hi[next_idx] = 1'b1;
    end
`ifdef DECODER_ACTIVE_LOW_EN
    next_y = ~next_y_hi;
`else
    next_y = next_y_hi;
`endif
  end

  // All outputs are registered; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      active <= 1'b0;
      wrap   <= 1'b0;
      y      <= Y_IDLE;
    end else begin
      state  <= next_state;
      idx    <= next_idx;
      active <= next_active;
      wrap   <= next_wrap;
      y      <= next_y;
    end
  end

  assign busy = (state == SCAN);

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decoder_scan_ctrl
// Drives two decoders (DWELL=4 and DWELL=1) with shared inputs and compares
// every registered output against a reference model that tracks scan
// position as elapsed time since scan entry.
// ---------------------------------------------------------------------------
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [2:0] sel = 3'd0;

  logic [7:0] y0, y1;
  logic [2:0] idx0, idx1;
  logic       busy0, busy1, wrap0, wrap1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.N(3), .DWELL(4), .CW(16)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
    .y(y0), .idx(idx0), .busy(busy0), .wrap(wrap0)
  );

  decoder_scan_ctrl #(.N(3), .DWELL(1), .CW(16)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
    .y(y1), .idx(idx1), .busy(busy1), .wrap(wrap1)
  );

  // Reference model: 0 idle, 1 direct, 2 scan. In scan the position is
  // derived from elapsed cycles since entry rather than from a counter.
  int m_state[2];
  int m_t[2];
  bit m_on[2];
  int m_idx[2];
  int dw[2];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_state[k] = 0; m_on[k] = 0; m_idx[k] = 0; m_t[k] = 0;
      end else if (!en) begin
        m_state[k] = 0; m_on[k] = 0; m_idx[k] = 0; m_t[k] = 0;
      end else if (mode) begin
        if (m_state[k] == 2) m_t[k]++;
        else begin m_state[k] = 2; m_t[k] = 0; end
      end else begin
        if (m_state[k] == 2) begin
          m_idx[k] = (m_t[k] / dw[k]) % 8;
          m_on[k] = 1;
        end else if (load) begin
          m_idx[k] = sel;
          m_on[k] = 1;
        end
        m_state[k] = 1;
      end
    end
  endtask

  function automatic logic [12:0] expect_vec(int k);
    logic [7:0] yy;
    int ix;
    bit b, w;
    if (m_state[k] == 2) begin
      ix = (m_t[k] / dw[k]) % 8;
      yy = 8'(1 << ix);
      b = 1;
      w = (m_t[k] > 0) && (m_t[k] % (8 * dw[k]) == 0);
    end else begin
      ix = m_idx[k];
      yy = m_on[k] ? 8'(1 << ix) : 8'h00;
      b = 0;
      w = 0;
    end
`ifdef DECODER_ACTIVE_LOW_EN
    yy = ~yy;
`endif
    return {yy, 3'(ix), b, w};
  endfunction

  // Waits for the active edge, advances the model, then settles past it.
  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    en = 1; mode = 1; rst = 1;
    for (int c = 0; c < 2; c++) begin
      advance();
      checks++;
      if ({y0, idx0, busy0, wrap0} !== expect_vec(0)) begin
        failures++;
        $display("[TB] FAIL reset_hold got=%h exp=%h", {y0, idx0, busy0, wrap0}, expect_vec(0));
      end
    end
    rst = 0;
    advance();
    checks++;
    if ({y0, idx0, busy0, wrap0} !== expect_vec(0)) begin
      failures++;
      $display("[TB] FAIL reset_release_scan got=%h exp=%h", {y0, idx0, busy0, wrap0}, expect_vec(0));
    end
  endtask

  task automatic test_direct();
    en = 0; mode = 0;
    advance();
    en = 1; load = 1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      advance();
      checks++;
      if ({y0, idx0, busy0, wrap0} !== expect_vec(0)) begin
        failures++;
        $display("[TB] FAIL direct_load sel=%0d got=%h exp=%h", s, {y0, idx0, busy0, wrap0}, expect_vec(0));
      end
    end
    load = 0; sel = 3'd2;
    for (int c = 0; c < 3; c++) begin
      advance();
      checks++;
      if ({y0, idx0, busy0, wrap0} !== expect_vec(0)) begin
        failures++;
        $display("[TB] FAIL direct_hold got=%h exp=%h", {y0, idx0, busy0, wrap0}, expect_vec(0));
      end
    end
  endtask

  task automatic test_scan();
    int wraps0 = 0;
    int wraps1 = 0;
    en = 0;
    advance();
    en = 1; mode = 1;
    for (int c = 0; c < 70; c++) begin
      load = 1'($urandom_range(0, 1));
      sel = 3'($urandom_range(0, 7));
      advance();
      wraps0 += wrap0;
      wraps1 += wrap1;
      checks++;
      if ({y0, idx0, busy0, wrap0} !== expect_vec(0)) begin
        failures++;
        $display("[TB] FAIL scan_dwell4 cyc=%0d got=%h exp=%h", c, {y0, idx0, busy0, wrap0}, expect_vec(0));
      end
      checks++;
      if ({y1, idx1, busy1, wrap1} !== expect_vec(1)) begin
        failures++;
        $display("[TB] FAIL scan_dwell1 cyc=%0d got=%h exp=%h", c, {y1, idx1, busy1, wrap1}, expect_vec(1));
      end
    end
    // 70 cycles from entry: wraps at t=32,64 (DWELL=4) and every 8 (DWELL=1).
    checks++;
    if (wraps0 != 2 || wraps1 != 8) begin
      failures++;
      $display("[TB] FAIL scan_wrap_count got=%0d/%0d exp=2/8", wraps0, wraps1);
    end
    load = 0;
  endtask

  task automatic test_mid_events();
    int n;
    // Restart scan from a clean entry, run to position 4, then drop en.
    en = 0; mode = 1;
    advance();
    en = 1;
    n = 0;
    do begin advance(); n++; end while (expect_vec(0)[12:5] != 8'(1 << 4) && expect_vec(0)[12:5] != ~8'(1 << 4) && n < 64);
    checks++;
    if (n >= 64) begin
      failures++;
      $display("[TB] FAIL wait_pos4 timeout got=%0d exp<64", n);
    end
    en = 0;
    advance();
    checks++;
    if ({y0, idx0, busy0, wrap0} !== expect_vec(0)) begin
      failures++;
      $display("[TB] FAIL disable_mid_scan got=%h exp=%h", {y0, idx0, busy0, wrap0}, expect_vec(0));
    end
    en = 1;
    advance();
    checks++;
    if ({y0, idx0, busy0, wrap0} !== expect_vec(0)) begin
      failures++;
      $display("[TB] FAIL reenable_restart got=%h exp=%h", {y0, idx0, busy0, wrap0}, expect_vec(0));
    end
    // Advance to position 2 (t=8..11) and switch to direct.
    for (int c = 0; c < 8; c++) advance();
    mode = 0; load = 0;
    for (int c = 0; c < 3; c++) begin
      advance();
      checks++;
      if ({y0, idx0, busy0, wrap0} !== expect_vec(0)) begin
        failures++;
        $display("[TB] FAIL scan_to_direct_hold got=%h exp=%h", {y0, idx0, busy0, wrap0}, expect_vec(0));
      end
    end
    load = 1; sel = 3'd6;
    advance();
    load = 0;
    checks++;
    if ({y0, idx0, busy0, wrap0} !== expect_vec(0)) begin
      failures++;
      $display("[TB] FAIL direct_load_after_scan got=%h exp=%h", {y0, idx0, busy0, wrap0}, expect_vec(0));
    end
    // Reset mid-scan.
    mode = 1;
    for (int c = 0; c < 6; c++) advance();
    rst = 1;
    advance();
    rst = 0;
    checks++;
    if ({y0, idx0, busy0, wrap0} !== expect_vec(0) || {y1, idx1, busy1, wrap1} !== expect_vec(1)) begin
      failures++;
      $display("[TB] FAIL reset_mid_scan got=%h/%h exp=%h/%h", {y0, idx0, busy0, wrap0}, {y1, idx1, busy1, wrap1}, expect_vec(0), expect_vec(1));
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      en   = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      load = 1'($urandom_range(0, 1));
      sel  = 3'($urandom_range(0, 7));
      advance();
      checks++;
      if ({y0, idx0, busy0, wrap0} !== expect_vec(0)) begin
        failures++;
        $display("[TB] FAIL random_dwell4 cyc=%0d got=%h exp=%h", c, {y0, idx0, busy0, wrap0}, expect_vec(0));
      end
      checks++;
      if ({y1, idx1, busy1, wrap1} !== expect_vec(1)) begin
        failures++;
        $display("[TB] FAIL random_dwell1 cyc=%0d got=%h exp=%h", c, {y1, idx1, busy1, wrap1}, expect_vec(1));
      end
    end
    rst = 0;
  endtask

  initial begin
    dw[0] = 4; dw[1] = 1;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_t[k] = 0; m_on[k] = 0; m_idx[k] = 0;
    end
    #2;
    test_reset();
    test_direct();
    test_scan();
    test_mid_events();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
